// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared memory-interface types, requester indices and the
//                tag-table entry layout used by the memory-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Memory interface types
  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } mem_command_t;

  localparam int MEM_TAG_W = 4;
  typedef logic [MEM_TAG_W-1:0] mem_tag_t;
  typedef logic [31:0]          addr_t;
  typedef logic [63:0]          mem_block_t;

  // Requester indices into the arbiter's request vectors
  localparam int REQ_WB      = 0;
  localparam int REQ_Q       = 1;
  localparam int REQ_R       = 2;
  localparam int NUM_MEM_REQ = 3;

  localparam int REQ_IDX_W = (NUM_MEM_REQ > 1) ? $clog2(NUM_MEM_REQ) : 1;

  // One slot of the tag table: which requester owns an in-flight load
  typedef struct packed {
    logic                 valid;
    logic [REQ_IDX_W-1:0] owner;
  } tag_entry_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. The search starts at ptr
//                and wraps; the first asserted request wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] winner,
  output logic          any
);

  int idx;

  // Scan requesters in rotated order starting at ptr; latch the first hit
  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        winner     = IW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one memory port between write-back, query fetch and
//                reference fetch. Round-robin grant, tag table routing of
//                returned load data, per-requester outstanding-load limits.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_MEM_REQ,
  parameter int MAX_OUTST = 8,
  parameter int TAG_W     = MEM_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  input  mem_command_t       req_cmd [NUM_REQ],
  input  addr_t              req_addr [NUM_REQ],
  input  mem_block_t         req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output logic [NUM_REQ-1:0] rsp_valid,
  output mem_block_t         rsp_data,
  input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
  input  mem_block_t         mem2proc_data,
  input  logic [TAG_W-1:0]   mem2proc_data_tag,
  output mem_command_t       proc2mem_command,
  output addr_t              proc2mem_addr,
  output mem_block_t         proc2mem_data,
  output logic               idle,
  output logic               err
);

  // Owner field width comes from the shared tag_entry_t layout
  localparam int IDX_W    = REQ_IDX_W;
  localparam int CNT_W    = $clog2(MAX_OUTST + 1);
  localparam int NUM_TAGS = 1 << TAG_W;

  logic [IDX_W-1:0] rr_ptr;
  tag_entry_t       tag_table [NUM_TAGS];
  logic [CNT_W-1:0] outst [NUM_REQ];
  logic             err_r;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   winner;
  logic               any_grant;
  mem_command_t       win_cmd;
  logic               accept;
  logic               load_accept;
  logic [IDX_W-1:0]   next_ptr;

  tag_entry_t         rsp_entry;
  tag_entry_t         alloc_entry;
  logic               data_tag_nz;
  logic               rsp_hit;
  logic               unmatched;
  logic               alloc_clash;
  logic [IDX_W-1:0]   rsp_owner;

  logic [NUM_REQ-1:0] cnt_inc;
  logic [NUM_REQ-1:0] cnt_dec;
  logic               any_outst;

  // Loads need a free outstanding slot; stores are untracked and always eligible
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_elig
      assign eligible[i] = req_valid[i] && (req_cmd[i] != MEM_NONE) &&
                           ((req_cmd[i] == MEM_STORE) || (outst[i] < CNT_W'(MAX_OUTST)));
      assign cnt_inc[i]  = load_accept && (winner == IDX_W'(i));
      assign cnt_dec[i]  = rsp_hit && (rsp_owner == IDX_W'(i));
    end
  endgenerate

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr (
    .req    (eligible),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner),
    .any    (any_grant)
  );

  assign win_cmd     = req_cmd[winner];
  assign accept      = !rst && any_grant && (mem2proc_transaction_tag != '0);
  assign load_accept = accept && (win_cmd == MEM_LOAD);
  assign next_ptr    = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);

  // Response lookup and allocation-target lookup in the tag table
  assign rsp_entry   = tag_table[mem2proc_data_tag];
  assign alloc_entry = tag_table[mem2proc_transaction_tag];
  assign data_tag_nz = (mem2proc_data_tag != '0);
  assign rsp_hit     = !rst && data_tag_nz && rsp_entry.valid;
  assign rsp_owner   = rsp_entry.owner;
  assign unmatched   = data_tag_nz && !rsp_entry.valid;
  // A tag retiring in the same cycle it is re-issued is a legal reuse, not a clash
  assign alloc_clash = load_accept && alloc_entry.valid &&
                       !(rsp_hit && (mem2proc_data_tag == mem2proc_transaction_tag));

  // Drive the memory port from the winner and route returned data to its owner
  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    req_ready        = '0;
    rsp_valid        = '0;
    rsp_data         = '0;
    if (!rst && any_grant) begin
      proc2mem_command = win_cmd;
      proc2mem_addr    = req_addr[winner];
      if (win_cmd == MEM_STORE) begin
        proc2mem_data = req_data[winner];
      end
    end
    if (accept) begin
      req_ready = grant;
    end
    if (rsp_hit) begin
      rsp_valid[rsp_owner] = 1'b1;
      rsp_data             = mem2proc_data;
    end
  end

  // Reduce outstanding counters for the idle indication
  always_comb begin
    any_outst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (outst[i] != '0) begin
        any_outst = 1'b1;
      end
    end
  end

  assign idle = !rst && !any_outst && !(|req_valid);
  assign err  = !rst && err_r;

  // Round-robin pointer advances only when memory takes the command
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= next_ptr;
    end
  end

  // Tag table: retire on response first, so a same-cycle allocation overrides it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        tag_table[t] <= '0;
      end
    end else begin
      if (rsp_hit) begin
        tag_table[mem2proc_data_tag].valid <= 1'b0;
      end
      if (load_accept) begin
        tag_table[mem2proc_transaction_tag] <= '{valid: 1'b1, owner: winner};
      end
    end
  end

  // Outstanding-load counters; issue and retire in one cycle cancel out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        outst[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i]) begin
          outst[i] <= outst[i] + CNT_W'(1);
        end else if (cnt_dec[i] && !cnt_inc[i]) begin
          outst[i] <= outst[i] - CNT_W'(1);
        end
      end
    end
  end

  // Sticky protocol error: unknown returning tag or overwrite of a live tag
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (unmatched || alloc_clash) begin
      err_r <= 1'b1;
    end
  end

endmodule
`default_nettype wire
